alu_exec_mc: RTL and testbench

//  Parametrised execute-stage ALU: the next generation of the single-cycle execute ALU.

---
 rtl/exec_pkg.sv | 7 +
 rtl/alu_iter_mul.sv | 56 +++++
 rtl/alu_exec_mc.sv | 95 +++++++++
 tb/tb_alu_exec_mc.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// exec_pkg: shared op bit map, FSM encoding and compare codes for the execute stage
package exec_pkg;
    localparam int OP_ADD = 0, OP_LD = 1, OP_ST = 2, OP_SUB = 3, OP_MUL = 4, OP_CMP = 5;
    localparam int OP_MOV = 6, OP_OR = 7, OP_AND = 8, OP_NOT = 9, OP_LSL = 10, OP_LSR = 11;
    localparam int CMP_LT = 0, CMP_EQ = 1, CMP_GT = 2;
    typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;
endpackage

// File: rtl/alu_iter_mul.sv
// alu_iter_mul: shift-add multiplier, one multiplier bit per cycle, WIDTH cycles per product
module alu_iter_mul #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic run_q, run_d;
    assign done    = run_q & (cnt_q == CW'(WIDTH));
    assign product = acc_q;
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (abort) run_d = 1'b0;
        else if (start) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (done) run_d = 1'b0;
        else if (run_q) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end
endmodule

// File: rtl/alu_exec_mc.sv
// alu_exec_mc: handshaked execute-stage ALU with iterative multiply, flush and stall-safe output
module alu_exec_mc
    import exec_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int IMM_W   = 5,
    parameter int INSTR_W = 16,
    parameter int NOPS    = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NOPS-1:0]    alusignals,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [WIDTH-1:0]   op1,
    input  logic [WIDTH-1:0]   op2,
    input  logic [IMM_W-1:0]   immx,
    input  logic               isimm,
    input  logic               iswb,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [INSTR_W-1:0] instr_out,
    output logic [WIDTH-1:0]   op2_out,
    output logic               isld_out,
    output logic               isst_out,
    output logic               iswb_out,
    output logic               busy
);
    localparam int SBW = INSTR_W + WIDTH + 3;
    state_t state_q, state_d;
    logic [WIDTH-1:0] b, alu_res, mul_prod, result_q, result_d;
    logic [SBW-1:0] sb_in, sb_q, sb_d, pend_q, pend_d;
    logic out_valid_q, out_valid_d, alive_q, grp_add, is_mul, shift_oob;
    logic accept, load_alu, mul_done, mul_fin;
    // alive_q keeps in_ready low for as long as reset is held
    assign in_ready = alive_q & (state_q == ST_IDLE) & (!out_valid_q | out_ready);
    assign busy     = state_q != ST_IDLE;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign {instr_out, op2_out, isld_out, isst_out, iswb_out} = sb_q;
    always_comb begin
        b         = isimm ? WIDTH'(immx) : op2;
        grp_add   = alusignals[OP_ADD] | alusignals[OP_LD] | alusignals[OP_ST];
        is_mul    = !grp_add && !alusignals[OP_SUB] && alusignals[OP_MUL];
        shift_oob = b >= WIDTH'(WIDTH);
        alu_res   = grp_add              ? op1 + b :
                    alusignals[OP_SUB]   ? op1 - b :
                    alusignals[OP_CMP]   ? (op1 == b ? WIDTH'(CMP_EQ) : op1 > b ? WIDTH'(CMP_GT) : WIDTH'(CMP_LT)) :
                    alusignals[OP_MOV]   ? b :
                    alusignals[OP_OR]    ? op1 | b :
                    alusignals[OP_AND]   ? op1 & b :
                    alusignals[OP_NOT]   ? ~op1 :
                    alusignals[OP_LSL]   ? (shift_oob ? '0 : op1 << b) :
                    alusignals[OP_LSR]   ? (shift_oob ? '0 : op1 >> b) : '0;
        accept      = in_valid & in_ready & !flush;
        load_alu    = accept & !is_mul;
        mul_fin     = (state_q == ST_MUL) & mul_done & !flush;
        state_d     = flush ? ST_IDLE : (accept & is_mul) ? ST_MUL : mul_fin ? ST_IDLE : state_q;
        out_valid_d = flush ? 1'b0 : (load_alu | mul_fin) ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
        sb_in       = {instr_in, op2, alusignals[OP_LD], alusignals[OP_ST], iswb};
        pend_d      = (accept & is_mul) ? sb_in : pend_q;
        result_d    = load_alu ? alu_res : mul_fin ? mul_prod : result_q;
        sb_d        = load_alu ? sb_in : mul_fin ? pend_q : sb_q;
    end
    alu_iter_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept & is_mul),
        .abort   (flush),
        .a       (op1),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            alive_q     <= 1'b0;
            result_q    <= '0;
            sb_q        <= '0;
            pend_q      <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            alive_q     <= 1'b1;
            result_q    <= result_d;
            sb_q        <= sb_d;
            pend_q      <= pend_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_mc.sv
// tb_alu_exec_mc: directed self-checking bench for alu_exec_mc
module tb_alu_exec_mc;
    logic clk = 1'b0, reset, flush, in_valid, in_ready, isimm, iswb, out_valid, out_ready;
    logic isld_out, isst_out, iswb_out, busy;
    logic [11:0] alusignals;
    logic [15:0] instr_in, op1, op2, result, instr_out, op2_out;
    logic [4:0] immx;
    int n_cmp = 0, n_err = 0;
    localparam logic [11:0] ADD = 12'h001, LD = 12'h002, ST = 12'h004, SUB = 12'h008, MUL = 12'h010;
    localparam logic [11:0] CMP = 12'h020, MOV = 12'h040, OR = 12'h080, AND = 12'h100, NOT = 12'h200;
    localparam logic [11:0] LSL = 12'h400, LSR = 12'h800;
    always #5 clk = ~clk;
    alu_exec_mc dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alusignals(alusignals), .instr_in(instr_in), .op1(op1), .op2(op2), .immx(immx),
        .isimm(isimm), .iswb(iswb), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .instr_out(instr_out), .op2_out(op2_out), .isld_out(isld_out), .isst_out(isst_out),
        .iswb_out(iswb_out), .busy(busy)
    );
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic op(input string tag, input logic [11:0] sig, input logic [15:0] a, input logic [15:0] bb,
                      input logic imm, input logic [4:0] ix, input logic [15:0] exp);
        in_valid = 1'b1; alusignals = sig; op1 = a; op2 = bb; isimm = imm; immx = ix;
        step();
        in_valid = 1'b0;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk(tag, 32'(result), 32'(exp));
    endtask
    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; isimm = 1'b0; iswb = 1'b0;
        alusignals = '0; instr_in = '0; op1 = '0; op2 = '0; immx = '0;
        step(); step();
        chk("rst_result", 32'(result), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b1;
        step();
        chk("in_ready_after_rst", 32'(in_ready), 1);
        instr_in = 16'hA001; iswb = 1'b1;
        op("add", ADD, 16'h1234, 16'h0FF0, 1'b0, 5'h00, 16'h2224);
        chk("add_instr", 32'(instr_out), 32'hA001);
        chk("add_op2", 32'(op2_out), 32'h0FF0);
        chk("add_wb", 32'(iswb_out), 1);
        iswb = 1'b0;
        step();
        chk("add_drained", 32'(out_valid), 0);
        op("lsl_oob", LSL, 16'h0001, 16'h0000, 1'b1, 5'h1F, 16'h0000);
        op("lsr_15", LSR, 16'h8000, 16'h0000, 1'b1, 5'd15, 16'h0001);
        op("lsl_4", LSL, 16'h0003, 16'h0004, 1'b0, 5'h00, 16'h0030);
        op("lsl_eq_w", LSL, 16'hFFFF, 16'd16, 1'b0, 5'h00, 16'h0000);
        op("sub_prio", SUB | OR, 16'h0005, 16'h0007, 1'b0, 5'h00, 16'hFFFE);
        op("st", ST, 16'h0100, 16'h0020, 1'b0, 5'h00, 16'h0120);
        chk("st_isst", 32'(isst_out), 1);
        chk("st_op2", 32'(op2_out), 32'h0020);
        op("ld", LD, 16'h0010, 16'h0001, 1'b0, 5'h00, 16'h0011);
        chk("ld_isld", 32'(isld_out), 1);
        op("cmp_eq", CMP, 16'h0003, 16'h0003, 1'b0, 5'h00, 16'h0001);
        op("cmp_lt", CMP, 16'h0002, 16'h0009, 1'b0, 5'h00, 16'h0000);
        op("mov_imm", MOV, 16'h1111, 16'h2222, 1'b1, 5'h0A, 16'h000A);
        op("or", OR, 16'h00F0, 16'h0F00, 1'b0, 5'h00, 16'h0FF0);
        op("and", AND, 16'hF0F0, 16'h3C3C, 1'b0, 5'h00, 16'h3030);
        op("not", NOT, 16'h00FF, 16'h0000, 1'b0, 5'h00, 16'hFF00);
        step();
        instr_in = 16'hBEEF; in_valid = 1'b1; alusignals = MUL; op1 = 16'h0101; op2 = 16'h0003; isimm = 1'b0;
        step();
        in_valid = 1'b0; instr_in = 16'h0000;
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("mul_in_ready_%0d", i), 32'(in_ready), 0);
            chk($sformatf("mul_out_valid_%0d", i), 32'(out_valid), 0);
            if (i == 0 || i == 15) chk($sformatf("mul_busy_%0d", i), 32'(busy), 1);
            step();
        end
        chk("mul_done_valid", 32'(out_valid), 1);
        chk("mul_result", 32'(result), 32'h0303);
        chk("mul_instr", 32'(instr_out), 32'hBEEF);
        chk("mul_busy_end", 32'(busy), 0);
        step();
        out_ready = 1'b0;
        op("cmp_gt", CMP, 16'h0007, 16'h0003, 1'b0, 5'h00, 16'h0002);
        in_valid = 1'b1; alusignals = ADD; op1 = 16'h0001; op2 = 16'h0004;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_valid_%0d", i), 32'(out_valid), 1);
            chk($sformatf("stall_result_%0d", i), 32'(result), 2);
            chk($sformatf("stall_in_ready_%0d", i), 32'(in_ready), 0);
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("b2b_valid", 32'(out_valid), 1);
        chk("b2b_result", 32'(result), 5);
        step();
        chk("b2b_drained", 32'(out_valid), 0);
        in_valid = 1'b1; alusignals = MUL; op1 = 16'h0101; op2 = 16'h0003;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("flush_pre_busy", 32'(busy), 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 0);
        chk("flush_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("flush_no_valid_%0d", i), 32'(out_valid), 0);
            step();
        end
        op("post_flush_add", ADD, 16'h0002, 16'h0003, 1'b0, 5'h00, 16'h0005);
        step();
        instr_in = 16'h7777;
        in_valid = 1'b1; alusignals = MUL; op1 = 16'h0101; op2 = 16'h0003;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        #2 reset = 1'b0;
        #1;
        chk("arst_result", 32'(result), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_in_ready", 32'(in_ready), 0);
        chk("arst_out_valid", 32'(out_valid), 0);
        reset = 1'b1;
        step();
        op("rst_add", ADD, 16'h0010, 16'h0020, 1'b0, 5'h00, 16'h0030);
        op("no_op", 12'h000, 16'h0005, 16'h0006, 1'b0, 5'h00, 16'h0000);
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
